// File: rtl/m2_pkg.sv
// Shared types and constants for the milestone-2 S' fetch path.
// S' segment layout in SRAM: Y is 320 words/row, U and V are 160 words/row, 240 rows each.
package m2_pkg;

  typedef enum logic [1:0] {
    SEG_Y = 2'b00,
    SEG_U = 2'b01,
    SEG_V = 2'b10
  } seg_t;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_ISSUE = 2'd1,
    FETCH_DRAIN = 2'd2,
    FETCH_DONE  = 2'd3
  } m2_fetch_state_t;

  localparam logic [17:0] Y_SP_BASE   = 18'd76800;
  localparam logic [17:0] U_SP_BASE   = 18'd153600;
  localparam logic [17:0] V_SP_BASE   = 18'd192000;
  localparam logic [8:0]  Y_SP_WIDTH  = 9'd320;
  localparam logic [8:0]  UV_SP_WIDTH = 9'd160;
  localparam logic [5:0]  Y_BLK_COLS  = 6'd40;
  localparam logic [5:0]  UV_BLK_COLS = 6'd20;
  localparam logic [4:0]  BLK_ROWS    = 5'd30;

  function automatic logic [17:0] seg_base(input logic [1:0] seg);
    case (seg)
      SEG_U:   return U_SP_BASE;
      SEG_V:   return V_SP_BASE;
      default: return Y_SP_BASE;
    endcase
  endfunction

endpackage

// File: rtl/m2_block_addr_gen.sv
// Walks the 64 SRAM addresses of one 8x8 S' block in row-major order.
// The block origin is built from shifts only; each row advance adds the segment width.
module m2_block_addr_gen
  import m2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [1:0]  seg_sel,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  output logic [17:0] address,
  output logic        last,
  output logic        legal
);

  logic [17:0] row_start;
  logic [17:0] start_addr;
  logic [17:0] row_off;
  logic [17:0] col_off;
  logic [17:0] rowx;
  logic [8:0]  width;
  logic [8:0]  width_q;
  logic [5:0]  col_limit;
  logic [2:0]  c;
  logic [2:0]  r;
  logic        is_y;

  always_comb begin
    is_y       = (seg_sel == SEG_Y);
    width      = is_y ? Y_SP_WIDTH : UV_SP_WIDTH;
    col_limit  = is_y ? Y_BLK_COLS : UV_BLK_COLS;
    legal      = (seg_sel != 2'b11) && (block_row < BLK_ROWS) && (block_col < col_limit);
    rowx       = {13'd0, block_row};
    // block_row*8*W: 2560 = 2048+512 for Y, 1280 = 1024+256 for U/V
    row_off    = is_y ? ((rowx << 11) + (rowx << 9)) : ((rowx << 10) + (rowx << 8));
    col_off    = {9'd0, block_col, 3'd0};
    start_addr = seg_base(seg_sel) + row_off + col_off;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_start <= '0;
      width_q   <= '0;
      c         <= '0;
      r         <= '0;
    end else if (load) begin
      row_start <= start_addr;
      width_q   <= width;
      c         <= '0;
      r         <= '0;
    end else if (advance) begin
      if (c == 3'd7) begin
        c         <= '0;
        r         <= r + 3'd1;
        row_start <= row_start + {9'd0, width_q};
      end else begin
        c <= c + 3'd1;
      end
    end
  end

  assign address = row_start + {15'd0, c};
  assign last    = (r == 3'd7) && (c == 3'd7);

endmodule

// File: rtl/m2_sprime_fetch.sv
// Fetches one 8x8 S' block from SRAM and writes it, sign-extended, into the
// milestone-2 DP-RAM port A. One block per accepted start pulse.
module m2_sprime_fetch
  import m2_pkg::*;
#(
  parameter int unsigned SRAM_RD_LAT = 3
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        start,
  input  logic [1:0]  seg_sel,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [6:0]  dpram_addr,
  output logic [31:0] dpram_wdata,
  output logic        dpram_wren,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] S_IDLE  = FETCH_IDLE;
  localparam logic [1:0] S_ISSUE = FETCH_ISSUE;
  localparam logic [1:0] S_DRAIN = FETCH_DRAIN;
  localparam logic [1:0] S_DONE  = FETCH_DONE;

  logic [1:0]             state;
  logic [SRAM_RD_LAT-1:0] vld;
  logic [6:0]             wr_cnt;
  logic                   load;
  logic                   issuing;
  logic                   advance;
  logic                   last;
  logic                   legal;

  always_comb begin
    load    = (state == S_IDLE) && start && legal;
    issuing = (state == S_ISSUE);
    advance = issuing && !last;
  end

  // SRAM_address comes straight from the generator registers, so it holds
  // its last value whenever the generator is neither loaded nor advanced.
  m2_block_addr_gen u_addr_gen (
    .clk       (CLOCK_50_I),
    .rst       (Reset),
    .load      (load),
    .advance   (advance),
    .seg_sel   (seg_sel),
    .block_row (block_row),
    .block_col (block_col),
    .address   (SRAM_address),
    .last      (last),
    .legal     (legal)
  );

  assign SRAM_we_n = 1'b1;

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (legal) begin
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= S_ISSUE;
            end else begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_ISSUE: if (last) state <= S_DRAIN;
        S_DRAIN: begin
          if ((wr_cnt == 7'd64) && !dpram_wren) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A tag enters when an address is on the bus and emerges with its read data.
  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) vld <= '0;
    else       vld <= (vld << 1) | SRAM_RD_LAT'(issuing);
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      dpram_wren  <= 1'b0;
      dpram_wdata <= '0;
      dpram_addr  <= '0;
      wr_cnt      <= '0;
    end else begin
      dpram_wren <= vld[SRAM_RD_LAT-1];
      if (load) begin
        wr_cnt <= '0;
      end else if (vld[SRAM_RD_LAT-1]) begin
        dpram_addr  <= wr_cnt;
        dpram_wdata <= {{16{SRAM_read_data[15]}}, SRAM_read_data};
        wr_cnt      <= wr_cnt + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_m2_sprime_fetch.sv
// Directed bench for m2_sprime_fetch: 3-cycle SRAM read model plus a write
// scoreboard filled at each start and drained as DP-RAM writes appear.
module tb_m2_sprime_fetch;

  logic        CLOCK_50_I = 1'b0;
  logic        Reset;
  logic        start;
  logic [1:0]  seg_sel;
  logic [4:0]  block_row;
  logic [5:0]  block_col;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [6:0]  dpram_addr;
  logic [31:0] dpram_wdata;
  logic        dpram_wren;
  logic        busy;
  logic        done;
  logic        err;

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  m2_sprime_fetch #(.SRAM_RD_LAT(3)) dut (
    .CLOCK_50_I     (CLOCK_50_I),
    .Reset          (Reset),
    .start          (start),
    .seg_sel        (seg_sel),
    .block_row      (block_row),
    .block_col      (block_col),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_address   (SRAM_address),
    .SRAM_we_n      (SRAM_we_n),
    .dpram_addr     (dpram_addr),
    .dpram_wdata    (dpram_wdata),
    .dpram_wren     (dpram_wren),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  // SRAM model: data for an address appears three clocks after the address.
  logic        ovr_en;
  logic [17:0] ovr_addr;
  logic [15:0] ovr_data;
  logic [17:0] sp0 = '0;
  logic [17:0] sp1 = '0;
  logic [17:0] sp2 = '0;

  function automatic logic [15:0] sram_fn(input logic [17:0] a, input logic en,
                                          input logic [17:0] oa, input logic [15:0] od);
    if (en && (a == oa)) return od;
    return a[15:0];
  endfunction

  always @(posedge CLOCK_50_I) begin
    sp0 <= SRAM_address;
    sp1 <= sp0;
    sp2 <= sp1;
  end

  assign SRAM_read_data = sram_fn(sp2, ovr_en, ovr_addr, ovr_data);

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sbq[$];

  int total = 0;
  int bad   = 0;
  int cyc, nwr, ndone, nbusy, naddr_chg, first_wr, done_cyc;
  logic [17:0] amin, amax, prev_addr, a_before;
  logic [17:0] addr_at [0:127];
  logic [31:0] first_data;
  logic [6:0]  first_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc        = -1;
    nwr        = 0;
    ndone      = 0;
    nbusy      = 0;
    naddr_chg  = 0;
    first_wr   = -1;
    done_cyc   = -1;
    amin       = '1;
    amax       = '0;
    first_data = '0;
    first_a    = '0;
  endtask

  task automatic tick();
    wr_t e;
    @(posedge CLOCK_50_I);
    #1;
    cyc++;
    if (cyc >= 0 && cyc < 128) addr_at[cyc] = SRAM_address;
    if (cyc >= 1 && SRAM_address !== prev_addr) naddr_chg++;
    prev_addr = SRAM_address;
    if (cyc >= 0 && ndone == 0) begin
      if (SRAM_address < amin) amin = SRAM_address;
      if (SRAM_address > amax) amax = SRAM_address;
    end
    if (busy === 1'b1) nbusy++;
    if (dpram_wren === 1'b1) begin
      nwr++;
      if (first_wr < 0) begin
        first_wr   = cyc;
        first_data = dpram_wdata;
        first_a    = dpram_addr;
      end
      if (sbq.size() == 0) begin
        check("unexpected_wren", {31'd0, dpram_wren}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("wr_addr", {25'd0, dpram_addr}, {25'd0, e.a});
        check("wr_data", dpram_wdata, e.d);
      end
    end
    if (done === 1'b1) begin
      if (ndone == 0) done_cyc = cyc;
      ndone++;
    end
  endtask

  task automatic push_block(input int seg, input int row, input int col);
    int base, w, a;
    logic [15:0] d;
    logic signed [31:0] sd;
    wr_t e;
    case (seg)
      0:       begin base = 76800;  w = 320; end
      1:       begin base = 153600; w = 160; end
      default: begin base = 192000; w = 160; end
    endcase
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        a  = base + (row * 8 + r) * w + col * 8 + c;
        d  = sram_fn(18'(a), ovr_en, ovr_addr, ovr_data);
        sd = $signed(d);
        e.a = 7'(r * 8 + c);
        e.d = sd;
        sbq.push_back(e);
      end
    end
  endtask

  // Accepting edge is cycle 0; request inputs are scrambled afterwards.
  task automatic launch(input int seg, input int row, input int col, input bit push);
    clear_stats();
    if (push) push_block(seg, row, col);
    seg_sel   = 2'(seg);
    block_row = 5'(row);
    block_col = 6'(col);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    seg_sel   = 2'($urandom);
    block_row = 5'($urandom);
    block_col = 6'($urandom);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (ndone == 0 && n < bound) begin
      tick();
      n++;
    end
    check("done_seen", ndone, 1);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_addr"},  {14'd0, SRAM_address}, 32'd0);
    check({pfx, "_we_n"},  {31'd0, SRAM_we_n}, 32'd1);
    check({pfx, "_daddr"}, {25'd0, dpram_addr}, 32'd0);
    check({pfx, "_wdata"}, dpram_wdata, 32'd0);
    check({pfx, "_wren"},  {31'd0, dpram_wren}, 32'd0);
    check({pfx, "_busy"},  {31'd0, busy}, 32'd0);
    check({pfx, "_done"},  {31'd0, done}, 32'd0);
    check({pfx, "_err"},   {31'd0, err}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; seg_sel = '0; block_row = '0; block_col = '0;
    ovr_en = 1'b0; ovr_addr = '0; ovr_data = '0; prev_addr = '0;
    clear_stats();
    repeat (2) tick();
    check_idle_outputs("rst");
    Reset = 1'b0;
    tick();

    // Y block (0,0)
    launch(0, 0, 0, 1'b1);
    check("y_first_addr", {14'd0, addr_at[0]}, 32'd76800);
    check("y_busy", {31'd0, busy}, 32'd1);
    wait_done(150);
    check("y_first_wr_cyc", first_wr, 4);
    check("y_done_cyc", done_cyc, 69);
    check("y_nwr", nwr, 64);
    check("y_row1_addr", {14'd0, addr_at[8]}, 32'd77120);
    check("y_last_addr", {14'd0, addr_at[63]}, 32'd79047);
    check("y_min", {14'd0, amin}, 32'd76800);
    check("y_max", {14'd0, amax}, 32'd79047);
    check("y_addr_changes", naddr_chg, 63);
    check("y_sb_empty", sbq.size(), 0);
    tick();
    check("y_busy_off", {31'd0, busy}, 32'd0);
    check("y_done_pulse", {31'd0, done}, 32'd0);
    check("y_hold_addr", {14'd0, SRAM_address}, 32'd79047);

    // U block (29,19), the bottom-right corner
    launch(1, 29, 19, 1'b1);
    wait_done(150);
    check("u_first_addr", {14'd0, addr_at[0]}, 32'd190872);
    check("u_min", {14'd0, amin}, 32'd190872);
    check("u_max", {14'd0, amax}, 32'd191999);
    check("u_nwr", nwr, 64);
    check("u_done_cyc", done_cyc, 69);
    check("u_sb_empty", sbq.size(), 0);
    tick();

    // V block (0,0): negative and positive first coefficient
    ovr_en = 1'b1; ovr_addr = 18'd192000; ovr_data = 16'hFFF6;
    launch(2, 0, 0, 1'b1);
    wait_done(150);
    check("v_neg_data", first_data, 32'hFFFFFFF6);
    check("v_neg_daddr", {25'd0, first_a}, 32'd0);
    check("v_neg_nwr", nwr, 64);
    tick();
    ovr_data = 16'h0005;
    launch(2, 0, 0, 1'b1);
    wait_done(150);
    check("v_pos_data", first_data, 32'h00000005);
    check("v_pos_nwr", nwr, 64);
    ovr_en = 1'b0;
    tick();

    // Illegal: Y column 40
    a_before = SRAM_address;
    launch(0, 0, 40, 1'b0);
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_done", {31'd0, done}, 32'd1);
    check("ill_addr_hold", {14'd0, addr_at[0]}, {14'd0, a_before});
    repeat (6) tick();
    check("ill_ndone", ndone, 1);
    check("ill_nwr", nwr, 0);
    check("ill_addr_changes", naddr_chg, 0);
    check("ill_nbusy", nbusy, 0);
    check("ill_err_sticky", {31'd0, err}, 32'd1);
    launch(3, 0, 0, 1'b0);
    check("ill_seg11_err", {31'd0, err}, 32'd1);
    repeat (3) tick();
    launch(1, 30, 0, 1'b0);
    check("ill_row30_err", {31'd0, err}, 32'd1);
    repeat (3) tick();
    launch(1, 3, 7, 1'b1);
    check("err_cleared", {31'd0, err}, 32'd0);
    wait_done(150);
    check("after_ill_nwr", nwr, 64);
    tick();

    // Second start during ISSUE is ignored
    launch(0, 2, 3, 1'b1);
    repeat (9) tick();
    seg_sel = 2'd1; block_row = 5'd4; block_col = 6'd4; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(150);
    check("restart_nwr", nwr, 64);
    check("restart_done_cyc", done_cyc, 69);
    check("restart_sb_empty", sbq.size(), 0);
    repeat (8) tick();
    check("restart_ndone", ndone, 1);
    check("restart_busy", {31'd0, busy}, 32'd0);

    // Reset at the 30th write abandons the block
    launch(1, 5, 5, 1'b1);
    begin
      int n;
      n = 0;
      while (nwr < 30 && n < 100) begin
        tick();
        n++;
      end
    end
    check("rst30_reached", nwr, 30);
    Reset = 1'b1;
    tick();
    check_idle_outputs("midrst");
    sbq.delete();
    Reset = 1'b0;
    repeat (80) tick();
    check("midrst_nwr", nwr, 30);
    check("midrst_ndone", ndone, 0);

    // Fresh start after the abandoned block
    launch(2, 3, 4, 1'b1);
    check("fresh_first_addr", {14'd0, addr_at[0]}, 32'd195872);
    wait_done(150);
    check("fresh_first_wr_cyc", first_wr, 4);
    check("fresh_done_cyc", done_cyc, 69);
    check("fresh_nwr", nwr, 64);
    check("fresh_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
